// File: rtl/slow_clock_meter.sv
// Measures the period and high time of slow_clock in quick_clock cycles.
// Also flags lock after repeated equal periods, and timeout when slow_clock stops.
module slow_clock_meter #(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT     = 1000000,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             quick_clock,
  input  logic             reset,
  input  logic             slow_clock,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_V     = WIDTH'(1);
  localparam logic [MW-1:0]    LOCK_V    = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]    MONE_V    = MW'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   s_d_reg;
  logic                   s;
  logic                   rise;
  logic                   fall;

  logic [1:0]       state_reg,  state_next;
  logic [WIDTH-1:0] cnt_reg,    cnt_next;
  logic [WIDTH-1:0] hcnt_reg,   hcnt_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [WIDTH-1:0] high_reg,   high_next;
  logic             valid_reg,  valid_next;
  logic             locked_reg, locked_next;
  logic [MW-1:0]    match_reg,  match_next;
  logic [MW-1:0]    match_inc;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = slow_clock;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~s_d_reg;
  assign fall = ~s & s_d_reg;

  // Match count saturates so a long locked run cannot wrap back below LOCK_COUNT.
  assign match_inc = (match_reg == LOCK_V) ? LOCK_V : match_reg + MONE_V;

  always_comb begin
    cnt_next = cnt_reg;
    if (rise) begin
      cnt_next = ONE_V;
    end else if (cnt_reg != TIMEOUT_V) begin
      cnt_next = cnt_reg + ONE_V;
    end
  end

  always_comb begin
    hcnt_next = hcnt_reg;
    if (rise) begin
      hcnt_next = ONE_V;
    end else if (s && (hcnt_reg != TIMEOUT_V)) begin
      hcnt_next = hcnt_reg + ONE_V;
    end
  end

  always_comb begin
    state_next  = state_reg;
    period_next = period_reg;
    high_next   = high_reg;
    valid_next  = 1'b0;
    locked_next = locked_reg;
    match_next  = match_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_MEASURE;
        end else if (cnt_reg == TIMEOUT_V) begin
          state_next  = ST_TIMEOUT;
          locked_next = 1'b0;
          match_next  = '0;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_next = cnt_reg;
          valid_next  = 1'b1;
          // Compare against the previous period so lock means "stable", not "some value".
          if (cnt_reg == period_reg) begin
            match_next = match_inc;
            if (match_inc == LOCK_V) begin
              locked_next = 1'b1;
            end
          end else begin
            match_next  = '0;
            locked_next = 1'b0;
          end
        end else begin
          if (fall) begin
            high_next = hcnt_reg;
          end
          if (cnt_reg == TIMEOUT_V) begin
            state_next  = ST_TIMEOUT;
            locked_next = 1'b0;
            match_next  = '0;
          end
        end
      end
      ST_TIMEOUT: begin
        if (rise) begin
          state_next = ST_MEASURE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge quick_clock) begin
    if (reset) begin
      sync_reg   <= '0;
      s_d_reg    <= 1'b0;
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      hcnt_reg   <= '0;
      period_reg <= '0;
      high_reg   <= '0;
      valid_reg  <= 1'b0;
      locked_reg <= 1'b0;
      match_reg  <= '0;
    end else begin
      sync_reg   <= sync_next;
      s_d_reg    <= s;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hcnt_reg   <= hcnt_next;
      period_reg <= period_next;
      high_reg   <= high_next;
      valid_reg  <= valid_next;
      locked_reg <= locked_next;
      match_reg  <= match_next;
    end
  end

  assign period       = period_reg;
  assign high_time    = high_reg;
  assign period_valid = valid_reg;
  assign locked       = locked_reg;
  assign timeout      = (state_reg == ST_TIMEOUT);

endmodule

// File: tb/tb_slow_clock_meter.sv
// Bench for slow_clock_meter: a transaction-level model predicts each
// measurement when a rising edge is driven; a monitor pops and compares them.
module tb_slow_clock_meter;
  localparam int W  = 16;
  localparam int T  = 64;
  localparam int LC = 4;
  localparam int SS = 2;

  logic         quick_clock = 1'b0;
  logic         reset       = 1'b1;
  logic         slow_clock  = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         period_valid;
  logic         locked;
  logic         timeout;

  slow_clock_meter #(
    .WIDTH(W), .TIMEOUT(T), .LOCK_COUNT(LC), .SYNC_STAGES(SS)
  ) dut (
    .quick_clock (quick_clock),
    .reset       (reset),
    .slow_clock  (slow_clock),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 quick_clock = ~quick_clock;

  typedef struct {
    int p;
    int h;
    bit l;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  // Model state: measuring flag, last period/high time, match run, lock.
  int m_measuring;
  int m_period;
  int m_high;
  int m_match;
  bit m_locked;
  int last_rise;

  task automatic tick();
    @(posedge quick_clock);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    m_measuring = 0;
    m_period    = 0;
    m_high      = 0;
    m_match     = 0;
    m_locked    = 0;
    last_rise   = cyc;
  endtask

  task automatic drive_rise();
    int   gap;
    exp_t e;
    gap = cyc - last_rise;
    if (m_measuring != 0 && gap <= T) begin
      if (gap == m_period) begin
        if (m_match < LC) m_match++;
      end else begin
        m_match = 0;
      end
      m_locked = (m_match == LC);
      m_period = gap;
      e.p = gap;
      e.h = m_high;
      e.l = m_locked;
      sb.push_back(e);
    end else begin
      // Reference edge after reset, or first edge after a timeout.
      if (m_measuring != 0) begin
        m_match  = 0;
        m_locked = 0;
      end
      m_measuring = 1;
    end
    last_rise  = cyc;
    slow_clock = 1'b1;
  endtask

  task automatic drive_fall();
    if (m_measuring != 0 && (cyc - last_rise) <= T) m_high = cyc - last_rise;
    slow_clock = 1'b0;
  endtask

  task automatic toggle(input int hi, input int lo, input int n);
    repeat (n) begin
      drive_rise();
      idle(hi);
      drive_fall();
      idle(lo);
    end
  endtask

  task automatic check_zero(input string name);
    compared++;
    if (period !== '0 || high_time !== '0 || period_valid !== 1'b0 ||
        locked !== 1'b0 || timeout !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: got p=%0d h=%0d v=%0b l=%0b t=%0b want all 0",
               name, period, high_time, period_valid, locked, timeout);
    end
  endtask

  always @(negedge quick_clock) begin
    if (!reset && period_valid === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid: got p=%0d at cycle %0d want no valid", period, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (period !== W'(mon_e.p) || high_time !== W'(mon_e.h) || locked !== mon_e.l) begin
          mismatched++;
          $display("FAIL measurement: got p=%0d h=%0d l=%0b want p=%0d h=%0d l=%0b",
                   period, high_time, locked, mon_e.p, mon_e.h, mon_e.l);
        end else begin
          $display("valid cyc=%0d period=%0d high=%0d locked=%0b", cyc, period, high_time, locked);
        end
      end
    end
  end

  task automatic test_reset();
    reset      = 1'b1;
    slow_clock = 1'b0;
    idle(3);
    check_zero("reset_state");
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_divider();
    toggle(2, 2, 6);
    idle(1);
    compared++;
    if (locked !== 1'b1 || period !== W'(4) || high_time !== W'(2)) begin
      mismatched++;
      $display("FAIL divider_lock: got l=%0b p=%0d h=%0d want l=1 p=4 h=2", locked, period, high_time);
    end
  endtask

  task automatic test_relock();
    toggle(3, 3, 6);
    idle(1);
    compared++;
    if (locked !== 1'b1 || period !== W'(6)) begin
      mismatched++;
      $display("FAIL relock: got l=%0b p=%0d want l=1 p=6", locked, period);
    end
  endtask

  task automatic test_duty_latency();
    drive_rise();
    idle(2);
    compared++;
    if (period_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_early: got v=%0b want 0", period_valid);
    end
    tick();
    compared++;
    if (period_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL latency_edge: got v=%0b want 1", period_valid);
    end
    drive_fall();
    idle(5);
    toggle(3, 5, 5);
    compared++;
    if (period !== W'(8) || high_time !== W'(3)) begin
      mismatched++;
      $display("FAIL duty: got p=%0d h=%0d want p=8 h=3", period, high_time);
    end
  endtask

  task automatic test_timeout();
    toggle(2, 2, 6);
    while (cyc < last_rise + 2 + T) tick();
    compared++;
    if (timeout !== 1'b0 || locked !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_early: got t=%0b l=%0b want t=0 l=1", timeout, locked);
    end
    tick();
    compared++;
    if (timeout !== 1'b1 || locked !== 1'b0 || period !== W'(4) || high_time !== W'(2)) begin
      mismatched++;
      $display("FAIL timeout_set: got t=%0b l=%0b p=%0d h=%0d want t=1 l=0 p=4 h=2",
               timeout, locked, period, high_time);
    end
    drive_rise();
    idle(2);
    compared++;
    if (timeout !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_hold: got t=%0b want 1", timeout);
    end
    drive_fall();
    tick();
    compared++;
    if (timeout !== 1'b0 || period_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_clear: got t=%0b v=%0b want t=0 v=0", timeout, period_valid);
    end
    idle(1);
    toggle(2, 2, 2);
    compared++;
    if (period !== W'(4) || locked !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_restart: got p=%0d l=%0b want p=4 l=0", period, locked);
    end
  endtask

  task automatic test_reset_mid();
    drive_rise();
    idle(4);
    reset = 1'b1;
    sb.delete();
    repeat (3) begin
      tick();
      check_zero("reset_during");
    end
    reset = 1'b0;
    model_reset();
    m_measuring = 1;
    idle(4);
    check_zero("reset_after");
    drive_fall();
    idle(3);
    toggle(2, 2, 2);
    compared++;
    if (period !== W'(4) || high_time !== W'(2)) begin
      mismatched++;
      $display("FAIL reset_recover: got p=%0d h=%0d want p=4 h=2", period, high_time);
    end
  endtask

  task automatic test_timeout_boundary();
    bit to_seen;
    to_seen = 1'b0;
    drive_rise();
    repeat (2) begin
      idle(2);
      drive_fall();
      while (cyc < last_rise + T) begin
        tick();
        if (timeout !== 1'b0) to_seen = 1'b1;
      end
      drive_rise();
    end
    repeat (4) begin
      tick();
      if (timeout !== 1'b0) to_seen = 1'b1;
    end
    compared++;
    if (to_seen !== 1'b0 || period !== W'(T)) begin
      mismatched++;
      $display("FAIL timeout_boundary: got t_seen=%0b p=%0d want t_seen=0 p=%0d", to_seen, period, T);
    end
    drive_fall();
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_divider();
    test_relock();
    test_duty_latency();
    test_timeout();
    test_reset_mid();
    test_timeout_boundary();
    idle(5);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL pending_valids: got %0d outstanding want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
